// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/completion sequencer.
//   - fpuOp encodings as seen on the EX-stage opcode bus
//   - default per-class latencies (enabled clock edges)
//   - sequencer FSM state encoding
package fpu_pkg;

  localparam logic [3:0] FADD     = 4'd0;
  localparam logic [3:0] FSUB     = 4'd1;
  localparam logic [3:0] FMUL     = 4'd2;
  localparam logic [3:0] FDIV     = 4'd3;
  localparam logic [3:0] FSGNJ    = 4'd4;
  localparam logic [3:0] FMINMAX  = 4'd5;
  localparam logic [3:0] FSQRT    = 4'd6;
  localparam logic [3:0] FCMP     = 4'd7;
  localparam logic [3:0] FCVT_W_S = 4'd8;
  localparam logic [3:0] FCVT_S_W = 4'd9;
  localparam logic [3:0] FMSUB    = 4'd10;
  localparam logic [3:0] FMADD    = 4'd11;
  localparam logic [3:0] FNMADD   = 4'd12;
  localparam logic [3:0] FNMSUB   = 4'd13;

  localparam int LAT_ADD_DEF  = 7;
  localparam int LAT_MUL_DEF  = 5;
  localparam int LAT_DIV_DEF  = 6;
  localparam int LAT_CMP_DEF  = 1;
  localparam int LAT_SQRT_DEF = 16;
  localparam int LAT_CVT_DEF  = 6;
  localparam int CNT_W_DEF    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fpu_sequencer_if.sv
// Pipeline <-> FPU sequencer bundle.
//   master : EX-stage / FPU side (drives req, fpuOp, flush, result_in)
//   slave  : sequencer (drives fpu_sel, fpu_op_hold, stall, busy, done, result_out)
interface fpu_sequencer_if;

  logic        req;
  logic [3:0]  fpuOp;
  logic        flush;
  logic [31:0] result_in;
  logic        fpu_sel;
  logic [3:0]  fpu_op_hold;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result_out;

  modport master (
    output req, fpuOp, flush, result_in,
    input  fpu_sel, fpu_op_hold, stall, busy, done, result_out
  );

  modport slave (
    input  req, fpuOp, flush, result_in,
    output fpu_sel, fpu_op_hold, stall, busy, done, result_out
  );

endinterface

// File: rtl/fpu_latency_lut.sv
// Combinational fpuOp -> (latency - 1) lookup. Output is the counter preload
// value, so it can also be reused by hazard logic to predict completion.
//   fpu_op_i  : FPU operation code
//   lat_m1_o  : latency minus one, CNT_W bits
module fpu_latency_lut
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_CMP  = LAT_CMP_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic [3:0]       fpu_op_i,
  output logic [CNT_W-1:0] lat_m1_o
);

  int lat;

  always_comb begin
    lat = LAT_CMP;
    case (fpu_op_i)
      FADD, FSUB:                    lat = LAT_ADD;
      FMUL:                          lat = LAT_MUL;
      FDIV:                          lat = LAT_DIV;
      FSGNJ, FMINMAX, FCMP:          lat = LAT_CMP;
      FSQRT:                         lat = LAT_SQRT;
      FCVT_W_S, FCVT_S_W:            lat = LAT_CVT;
      FMSUB, FMADD, FNMADD, FNMSUB:  lat = LAT_MUL + LAT_ADD;
      // undefined codes are treated as single-cycle ops
      default:                       lat = LAT_CMP;
    endcase
    lat_m1_o = CNT_W'(lat - 1);
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Issue/completion controller for the multi-cycle FPU in the EX stage.
// Holds fpu_sel (FPU clock enable, inverse is the FPU async clear) for L+1
// edges, stalls the pipeline for the operation, captures the result and
// pulses done for one cycle.
//   clock : system clock
//   clear : asynchronous active-high reset
//   bus   : fpu_sequencer_if.slave (req/fpuOp/flush/result_in in,
//           fpu_sel/fpu_op_hold/stall/busy/done/result_out out)
//
// state   | meaning
// IDLE    | waiting for req & ~flush; issue cycle drives outputs combinationally
// RUN     | FPU enabled, counter counts L-1 down to 0, result captured at 0
// DONE    | one-cycle done pulse, stall released, req ignored
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_CMP  = LAT_CMP_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic           clock,
  input logic           clear,
  fpu_sequencer_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] lat_m1;
  logic             issue;
  logic             run;

  fpu_latency_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_CMP  (LAT_CMP),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CVT  (LAT_CVT),
    .CNT_W    (CNT_W)
  ) u_lut (
    .fpu_op_i (bus.fpuOp),
    .lat_m1_o (lat_m1)
  );

  // clear gates issue so every output reads 0 while reset is held, even
  // if req is still asserted
  assign issue = (state_q == ST_IDLE) & bus.req & ~bus.flush & ~clear;
  assign run   = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_RUN;
          cnt_d   = lat_m1;
          op_d    = bus.fpuOp;
        end
      end
      ST_RUN: begin
        // flush wins over completion: an aborted op never commits
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = bus.result_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // issue term lets the FPU see the op on the very first enabled edge
  assign bus.fpu_sel     = run | issue;
  assign bus.stall       = run | issue;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.fpu_op_hold = issue ? bus.fpuOp : op_q;
  assign bus.result_out  = result_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
module tb_fpu_sequencer;
  import fpu_pkg::*;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  fpu_sequencer_if bus();

  fpu_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},    32'(bus.fpu_sel),     0);
    chk({tag, "_stall"},  32'(bus.stall),       0);
    chk({tag, "_busy"},   32'(bus.busy),        0);
    chk({tag, "_done"},   32'(bus.done),        0);
    chk({tag, "_hold"},   32'(bus.fpu_op_hold), 0);
    chk({tag, "_result"}, bus.result_out,       0);
  endtask

  // completion monitor: every done pulse pops one expected result
  always @(negedge clock) begin
    if (!clear && bus.done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_out", bus.result_out, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1 with the sequencer idle; runs one full operation.
  task automatic do_op(input logic [3:0] op, input int lat, input logic [31:0] res);
    int   c0;
    exp_t e;
    c0    = cyc;
    e.res = res;
    e.cyc = c0 + lat + 1;
    sb.push_back(e);
    for (int c = 0; c <= lat + 1; c++) begin
      bus.req       = (c <= lat);
      bus.fpuOp     = op;
      bus.result_in = (c == lat) ? res : (32'hDEAD_0000 | 32'(c));
      @(negedge clock);
      chk("stall", 32'(bus.stall),   32'(c <= lat));
      chk("sel",   32'(bus.fpu_sel), 32'(c <= lat));
      chk("busy",  32'(bus.busy),    32'(c >= 1));
      chk("done",  32'(bus.done),    32'(c == lat + 1));
      if (c <= lat) chk("op_hold", 32'(bus.fpu_op_hold), 32'(op));
      @(posedge clock); #1;
    end
    bus.req = 1'b0;
  endtask

  initial begin
    logic [31:0] last_res;
    int          base;
    bit          en;

    clear         = 1'b1;
    bus.req       = 1'b0;
    bus.fpuOp     = 4'd0;
    bus.flush     = 1'b0;
    bus.result_in = 32'h0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(posedge clock); #1;

    // single operations of several latency classes
    do_op(FADD,  7,  32'h4040_0000);
    do_op(FSQRT, 16, 32'h3FB5_04F3);
    do_op(FMADD, 12, 32'h4120_0000);
    last_res = 32'h4120_0000;

    // flush mid-FDIV: no done, result untouched
    for (int c = 0; c <= 9; c++) begin
      bus.req       = (c <= 3);
      bus.flush     = (c == 3);
      bus.fpuOp     = FDIV;
      bus.result_in = 32'hBAD0_0000 | 32'(c);
      @(negedge clock);
      chk("fl_sel",    32'(bus.fpu_sel), 32'(c <= 3));
      chk("fl_stall",  32'(bus.stall),   32'(c <= 3));
      chk("fl_busy",   32'(bus.busy),    32'(c >= 1 && c <= 3));
      chk("fl_done",   32'(bus.done),    0);
      chk("fl_result", bus.result_out,   last_res);
      @(posedge clock); #1;
    end
    bus.flush = 1'b0;

    // back-to-back FMUL then FCMP with req held through the DONE cycle
    base = cyc;
    sb.push_back('{32'h40C0_0000, base + 6});
    sb.push_back('{32'h0000_0001, base + 9});
    for (int c = 0; c <= 9; c++) begin
      bus.req       = (c <= 8);
      bus.fpuOp     = (c <= 5) ? FMUL : FCMP;
      bus.result_in = (c == 5) ? 32'h40C0_0000 :
                      (c == 8) ? 32'h0000_0001 : (32'hCAFE_0000 | 32'(c));
      @(negedge clock);
      en = (c <= 5) || (c == 7) || (c == 8);
      chk("b2b_sel",   32'(bus.fpu_sel), 32'(en));
      chk("b2b_stall", 32'(bus.stall),   32'(en));
      chk("b2b_done",  32'(bus.done),    32'(c == 6 || c == 9));
      chk("b2b_busy",  32'(bus.busy),    32'(c != 0 && c != 7));
      if (c <= 5) chk("b2b_hold_mul", 32'(bus.fpu_op_hold), 32'(FMUL));
      if (c == 7 || c == 8) chk("b2b_hold_cmp", 32'(bus.fpu_op_hold), 32'(FCMP));
      @(posedge clock); #1;
    end
    bus.req = 1'b0;

    // async clear in cycle 4 of FSQRT, req still high
    for (int c = 0; c <= 3; c++) begin
      bus.req       = 1'b1;
      bus.fpuOp     = FSQRT;
      bus.result_in = 32'h1111_0000 | 32'(c);
      @(negedge clock);
      chk("clr_pre_sel", 32'(bus.fpu_sel), 1);
      @(posedge clock); #1;
    end
    #2 clear = 1'b1;
    #1;
    chk_all_zero("clr_async");
    bus.req = 1'b0;
    @(negedge clock);
    chk_all_zero("clr_held");
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk_all_zero("clr_released");
    @(posedge clock); #1;

    // clean re-issue after clear, then undefined op and a conversion
    do_op(FSQRT,    16, 32'h4000_0000);
    do_op(4'd15,    1,  32'h1234_5678);
    do_op(FCVT_S_W, 6,  32'h4B00_0000);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
